// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one 24-bit adder between two requesters,
// with per-transaction ack timeout and registered per-requester results.
module adder_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        R0_req,
   input  logic [23:0] R0_a,
   input  logic [23:0] R0_b,
   output logic        R0_ack,
   output logic [23:0] R0_z,
   output logic        R0_cout,
   output logic        R0_err,
   input  logic        R1_req,
   input  logic [23:0] R1_a,
   input  logic [23:0] R1_b,
   output logic        R1_ack,
   output logic [23:0] R1_z,
   output logic        R1_cout,
   output logic        R1_err,
   output logic        Adder_req,
   output logic [23:0] Adder_a,
   output logic [23:0] Adder_b,
   input  logic        Adder_ack,
   input  logic [23:0] Adder_z,
   input  logic        Adder_cout,
   output logic        Busy,
   output logic        Grant
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t      state_q, state_d;
   logic [1:0]  rst_sync_q, rst_sync_d;
   logic        rst_n;
   logic [23:0] a_q, a_d, b_q, b_d, z0_q, z0_d, z1_q, z1_d;
   logic        c0_q, c0_d, c1_q, c1_d, e0_q, e0_d, e1_q, e1_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic        grant_q, grant_d, last_q, last_d, areq_q, areq_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        sel, tmo, done;

   // Reset asserts asynchronously but releases two edges later, clean of RSTn timing
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) rst_sync_q <= 2'b00;
      else       rst_sync_q <= rst_sync_d;
   end

   assign sel  = (R0_req && R1_req) ? ~last_q : R1_req;
   assign tmo  = areq_q && (cnt_q == 8'(TIMEOUT - 1));
   assign done = Adder_ack || tmo;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      z0_d    = z0_q;
      z1_d    = z1_q;
      c0_d    = c0_q;
      c1_d    = c1_q;
      e0_d    = e0_q;
      e1_d    = e1_q;
      grant_d = grant_q;
      last_d  = last_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      areq_d  = 1'b0;
      cnt_d   = 8'd0;
      case (state_q)
         IDLE: begin
            if (R0_req || R1_req) begin
               state_d = ISSUE;
               grant_d = sel;
               a_d     = sel ? R1_a : R0_a;
               b_d     = sel ? R1_b : R0_b;
            end
         end
         ISSUE: begin
            areq_d = !done;
            cnt_d  = areq_q ? cnt_q + 8'd1 : 8'd0;
            if (done) begin
               state_d = RESP;
               ack0_d  = !grant_q;
               ack1_d  = grant_q;
               if (grant_q) begin
                  z1_d = Adder_ack ? Adder_z : 24'd0;
                  c1_d = Adder_ack && Adder_cout;
                  e1_d = !Adder_ack;
               end else begin
                  z0_d = Adder_ack ? Adder_z : 24'd0;
                  c0_d = Adder_ack && Adder_cout;
                  e0_d = !Adder_ack;
               end
            end
         end
         RESP: begin
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= 24'd0;
         b_q     <= 24'd0;
         z0_q    <= 24'd0;
         z1_q    <= 24'd0;
         c0_q    <= 1'b0;
         c1_q    <= 1'b0;
         e0_q    <= 1'b0;
         e1_q    <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         areq_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         z0_q    <= z0_d;
         z1_q    <= z1_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         areq_q  <= areq_d;
         cnt_q   <= cnt_d;
      end
   end

   assign R0_ack    = ack0_q;
   assign R0_z      = z0_q;
   assign R0_cout   = c0_q;
   assign R0_err    = e0_q;
   assign R1_ack    = ack1_q;
   assign R1_z      = z1_q;
   assign R1_cout   = c1_q;
   assign R1_err    = e1_q;
   assign Adder_req = areq_q;
   assign Adder_a   = a_q;
   assign Adder_b   = b_q;
   assign Busy      = state_q != IDLE;
   assign Grant     = grant_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter with a behavioural adder,
// round-robin prediction model and a decoupled output monitor.
module tb_adder_arbiter;
   localparam int TO = 8;

   typedef struct {
      int          idx;
      logic [23:0] a, b, z;
      logic        cout, err;
      int          lat;
   } exp_t;

   logic        CLK, RSTn;
   logic        req[2];
   logic [23:0] ra[2], rb[2];
   logic        R0_ack, R0_cout, R0_err, R1_ack, R1_cout, R1_err;
   logic [23:0] R0_z, R1_z;
   logic        Adder_req, Adder_ack, Adder_cout, Busy, Grant;
   logic [23:0] Adder_a, Adder_b, Adder_z;

   exp_t        q[$];
   int          checks, errors, cyc, rise, stall, last, ack_delay, rcnt;
   int          stray_req, stray_done;
   logic        prev_req, stray_seen;
   logic [23:0] m_z[2];
   logic        m_c[2], m_e[2];
   logic [23:0] opa[2][4], opb[2][4];

   adder_arbiter #(.TIMEOUT(TO)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .R0_req(req[0]), .R0_a(ra[0]), .R0_b(rb[0]),
      .R0_ack(R0_ack), .R0_z(R0_z), .R0_cout(R0_cout), .R0_err(R0_err),
      .R1_req(req[1]), .R1_a(ra[1]), .R1_b(rb[1]),
      .R1_ack(R1_ack), .R1_z(R1_z), .R1_cout(R1_cout), .R1_err(R1_err),
      .Adder_req(Adder_req), .Adder_a(Adder_a), .Adder_b(Adder_b),
      .Adder_ack(Adder_ack), .Adder_z(Adder_z), .Adder_cout(Adder_cout),
      .Busy(Busy), .Grant(Grant)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // Shared adder: acks ack_delay cycles after Adder_req rises (0 = never)
   initial begin
      Adder_ack = 1'b0; Adder_z = 24'd0; Adder_cout = 1'b0; rcnt = 0; stray_done = 0;
      forever begin
         @(posedge CLK); #1;
         Adder_ack = 1'b0;
         if (stray_req != stray_done) begin
            stray_done = stray_req;
            Adder_ack  = 1'b1;
            Adder_z    = 24'($urandom);
            Adder_cout = 1'b1;
         end else if (Adder_req) begin
            rcnt++;
            if (rcnt == ack_delay) begin
               Adder_ack = 1'b1;
               {Adder_cout, Adder_z} = 25'(Adder_a) + 25'(Adder_b);
            end
         end else rcnt = 0;
      end
   end

   always @(negedge CLK) begin
      exp_t e;
      logic o;
      cyc++;
      if (!RSTn) begin
         chk("reset_outputs", {R0_ack, R0_z, R0_cout, R0_err, R1_ack, R1_z, R1_cout, R1_err,
                               Adder_req, Adder_a, Adder_b, Busy, Grant}, 128'd0);
         q.delete();
         m_z[0] = 24'd0; m_z[1] = 24'd0;
         m_c[0] = 1'b0;  m_c[1] = 1'b0;
         m_e[0] = 1'b0;  m_e[1] = 1'b0;
         prev_req = 1'b0; stray_seen = 1'b0; stall = 0;
      end else begin
         if (stray_seen) begin
            chk("stray_ack_ignored", {R0_z, R0_cout, R0_err, R1_z, R1_cout, R1_err,
                                      R0_ack, R1_ack, Busy, Adder_req},
                {m_z[0], m_c[0], m_e[0], m_z[1], m_c[1], m_e[1], 4'b0000});
            stray_seen = 1'b0;
         end
         if (Adder_ack && !Busy && !Adder_req) stray_seen = 1'b1;
         if (Adder_req && !prev_req) begin
            rise = cyc;
            if (q.size() != 0)
               chk("adder_operands", {Adder_a, Adder_b, Grant}, {q[0].a, q[0].b, q[0].idx[0]});
         end
         if (R0_ack || R1_ack) begin
            stall = 0;
            if (q.size() == 0) chk("unexpected_ack", {R0_ack, R1_ack}, 2'b00);
            else begin
               e = q.pop_front();
               o = R1_ack;
               chk("ack_owner", {R0_ack, R1_ack, Grant}, (e.idx == 1) ? 3'b011 : 3'b100);
               chk("result", o ? {R1_z, R1_cout, R1_err} : {R0_z, R0_cout, R0_err},
                   {e.z, e.cout, e.err});
               chk("latency", cyc - rise, e.lat);
               chk("resp_adder_req_low", {Adder_req, Busy}, 2'b01);
               chk("nonowner_hold", o ? {R0_z, R0_cout, R0_err} : {R1_z, R1_cout, R1_err},
                   {m_z[!o], m_c[!o], m_e[!o]});
               m_z[o] = e.z; m_c[o] = e.cout; m_e[o] = e.err;
            end
         end else if (q.size() != 0) begin
            stall++;
            if (stall > 300) begin
               checks++; errors++;
               $display("FAIL ack_wait: no ack for requester %0d within 300 cycles", q[0].idx);
               void'(q.pop_front());
               stall = 0;
            end
         end
         prev_req = Adder_req;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Reference: adder result or timeout outcome, round-robin pointer follows served owner
   task automatic expect_tx(input int i, input logic [23:0] a, input logic [23:0] b);
      exp_t e;
      e.idx = i; e.a = a; e.b = b;
      if (ack_delay == 0 || ack_delay > TO) begin
         e.z = 24'd0; e.cout = 1'b0; e.err = 1'b1; e.lat = TO;
      end else begin
         {e.cout, e.z} = 25'(a) + 25'(b);
         e.err = 1'b0; e.lat = ack_delay;
      end
      q.push_back(e);
      last = i;
   endtask

   task automatic serve(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         ra[i] = opa[i][k]; rb[i] = opb[i][k]; req[i] = 1'b1;
         for (int t = 0; t < 400; t++) begin
            @(negedge CLK);
            if ((i == 0) ? R0_ack : R1_ack) break;
         end
         tick(1);
      end
      req[i] = 1'b0;
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 2000 && q.size() != 0; t++) tick(1);
      tick(2);
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      tick(3);
      RSTn = 1'b1;
      last = 1;
      tick(3);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++) begin
            opa[i][k] = 24'($urandom);
            opb[i][k] = 24'($urandom);
         end
   endtask

   initial begin
      int w;
      checks = 0; errors = 0; cyc = 0; rise = 0; stall = 0; stray_req = 0;
      req[0] = 1'b0; req[1] = 1'b0;
      ra[0] = 24'd0; ra[1] = 24'd0; rb[0] = 24'd0; rb[1] = 24'd0;
      ack_delay = 3; last = 1;
      RSTn = 1'b1;
      #1 RSTn = 1'b0;
      tick(3);
      RSTn = 1'b1;
      tick(3);

      ack_delay = 3;
      opa[0][0] = 24'h000001; opb[0][0] = 24'h7FFFFF;
      expect_tx(0, opa[0][0], opb[0][0]);
      serve(0, 1);
      wait_idle();

      ack_delay = int'($urandom_range(1, 6));
      opa[1][0] = 24'hFFFFFF; opb[1][0] = 24'h000001;
      expect_tx(1, opa[1][0], opb[1][0]);
      serve(1, 1);
      wait_idle();

      do_reset();
      ack_delay = 2;
      rand_ops();
      for (int k = 0; k < 2; k++) begin
         expect_tx(0, opa[0][k], opb[0][k]);
         expect_tx(1, opa[1][k], opb[1][k]);
      end
      fork
         serve(0, 2);
         serve(1, 2);
      join
      wait_idle();

      ack_delay = 0;
      rand_ops();
      expect_tx(0, opa[0][0], opb[0][0]);
      serve(0, 1);
      tick(2);
      stray_req++;
      tick(4);

      for (int d = TO; d <= TO + 1; d++) begin
         ack_delay = d;
         rand_ops();
         expect_tx(1, opa[1][0], opb[1][0]);
         serve(1, 1);
         wait_idle();
      end

      for (int it = 0; it < 24; it++) begin
         int mode;
         mode = int'($urandom_range(0, 2));
         ack_delay = int'($urandom_range(0, 9));
         rand_ops();
         if (mode < 2) begin
            expect_tx(mode, opa[mode][0], opb[mode][0]);
            serve(mode, 1);
         end else begin
            w = 1 - last;
            expect_tx(w, opa[w][0], opb[w][0]);
            expect_tx(1 - w, opa[1-w][0], opb[1-w][0]);
            fork
               serve(0, 1);
               serve(1, 1);
            join
         end
         wait_idle();
         tick(int'($urandom_range(0, 3)));
      end

      ack_delay = 0;
      rand_ops();
      expect_tx(1, opa[1][0], opb[1][0]);
      fork
         serve(1, 1);
         begin
            for (int t = 0; t < 20 && !Adder_req; t++) tick(1);
            tick(2);
            RSTn = 1'b0;
            tick(2);
            RSTn = 1'b1;
            last = 1;
            ack_delay = 4;
            expect_tx(1, opa[1][0], opb[1][0]);
         end
      join
      wait_idle();

      tick(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, the maximum number of cycles to wait for Adder_ack per transaction (range 2..255).
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RSTn  input  1  asynchronous, active-low reset.
REQ-004 R0_req  input  1  requester 0 request; held high with stable operands until R0_ack.
REQ-005 R0_a, R0_b  input  24 each  requester 0 operands.
REQ-006 R0_ack  output  1  one-cycle completion pulse to requester 0.
REQ-007 R0_z  output  24  registered sum for requester 0.
REQ-008 R0_cout  output  1  registered carry-out for requester 0.
REQ-009 R0_err  output  1  timeout flag; valid while R0_ack is high.
REQ-010 R1_req, R1_a, R1_b, R1_ack, R1_z, R1_cout, R1_err  same directions, widths and meanings, for requester 1.
REQ-011 Adder_req  output  1  request to the shared 24-bit adder (adder_24b REQ).
REQ-012 Adder_a, Adder_b  output  24 each  operands to the adder.
REQ-013 Adder_ack  input  1  adder completion pulse.
REQ-014 Adder_z  input  24  adder sum; valid while Adder_ack is high.
REQ-015 Adder_cout  input  1  adder carry-out; valid while Adder_ack is high.
REQ-016 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-017 Grant  output  1  index of the current or most recent owner.

Function
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-019 In IDLE, if any request is high, the FSM SHALL select an owner, latch that owner's operands into Adder_a/Adder_b, set Grant, and go to ISSUE on the next edge.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests the requester not served last wins; with a single request, that requester wins.
REQ-021 The round-robin pointer SHALL update only when a transaction completes in RESP.
REQ-022 In ISSUE, Adder_req SHALL be high (registered) and Adder_a/Adder_b SHALL be held stable.
REQ-023 When Adder_ack is high in ISSUE, the block SHALL capture Adder_z/Adder_cout into the owner's z/cout registers, clear the owner's err, and go to RESP.
REQ-024 In ISSUE, a cycle counter SHALL count from 0; if it reaches TIMEOUT-1 without Adder_ack, the block SHALL go to RESP with the owner's err=1 and the owner's z/cout cleared to 0.
REQ-025 In RESP, Adder_req SHALL be 0 and the owner's ack SHALL be 1 for exactly that one cycle; the next state SHALL be IDLE.
REQ-026 Minimum latency SHALL be as follows: request sampled at edge 0; Adder_req high after edge 1; for Adder_ack in the first ISSUE cycle, owner ack is high after edge 2.
REQ-027 Adder_req SHALL be low for at least one cycle (RESP) between consecutive transactions.
REQ-028 A non-owner's z/cout/err SHALL hold their values while the other requester is served.
REQ-029 Adder_ack outside ISSUE SHALL be ignored, with no state or output change.
REQ-030 A request that drops in ISSUE SHALL NOT abort the transaction; it completes normally.
REQ-031 The sum width SHALL be 24 bits, with the carry passed through unmodified; no arithmetic is performed in this block.

Reset
REQ-032 On RSTn low, the block SHALL immediately (asynchronously) enter IDLE with all outputs 0: Adder_req, Adder_a, Adder_b, R0/R1 ack, z, cout, err, Busy and Grant.
REQ-033 On reset, the round-robin pointer SHALL favour requester 0, and the timeout counter SHALL clear to 0.
REQ-034 Reset asserted in ISSUE or RESP SHALL abandon the transaction with no ack pulse; after release, pending requests are arbitrated fresh.
REQ-035 Release of RSTn SHALL be synchronised internally so that the first active edge is glitch-free.

Verification
REQ-036 Single request: R0 with a=0x000001, b=0x7FFFFF; adder acks after 3 cycles -> R0_ack pulses once, R0_z=0x800000, R0_cout=0, R0_err=0, Grant=0.
REQ-037 Carry: R1 with a=0xFFFFFF, b=0x000001 -> R1_z=0x000000, R1_cout=1; R0 outputs unchanged.
REQ-038 Contention: both requests held from the same cycle after reset -> R0 served first, then R1. With both held high for 4 transactions, grants alternate 0,1,0,1 and Adder_req is low one cycle between each.
REQ-039 Timeout: TIMEOUT=8, adder never acks -> owner ack occurs 8 cycles after Adder_req rises, with err=1 and z=0. A late Adder_ack in IDLE is ignored.
REQ-040 Reset mid-ISSUE: RSTn pulled low while Adder_req=1 -> all outputs 0 immediately and no ack pulse. After release, a held R1_req is served.
